// File: rtl/mem_map_pkg.sv
// Shared address map, region and FSM types for the memory responder.
// Region bases are aligned, so a region index is simply the low address bits.
package mem_map_pkg;

  localparam logic [7:0] ROM_BASE = 8'h00;
  localparam logic [7:0] RAM_BASE = 8'h80;
  localparam logic [7:0] OUT_BASE = 8'hE0;
  localparam logic [7:0] IN_BASE  = 8'hF0;

  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_OUT, REG_IN} region_t;
  typedef enum logic {BOOT, RUN} resp_state_t;

  function automatic region_t region_of(input logic [7:0] a);
    region_t r;
    if (a >= IN_BASE)       r = REG_IN;
    else if (a >= OUT_BASE) r = REG_OUT;
    else if (a >= RAM_BASE) r = REG_RAM;
    else if (a >= ROM_BASE) r = REG_ROM;
    else                    r = REG_ROM;
    return r;
  endfunction

endpackage

// File: rtl/port_sync.sv
// Two-flop synchroniser for one 8-bit asynchronous input port.
// Latency: 2 clk edges from port change to q; no backpressure.
module port_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/memory_responder.sv
// MAR-addressed memory/IO responder: ROM, RAM, output and synchronised input ports plus boot loader.
// Latency: read data registered one edge after MAR settles; no backpressure, every strobe is accepted.
module memory_responder
  import mem_map_pkg::*;
#(
  parameter int ROM_DEPTH = 128,
  parameter int RAM_DEPTH = 96,
  parameter int N_OUT     = 16,
  parameter int N_IN      = 16,
  parameter bit BOOT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mar_load,
  input  logic [7:0]       mar_addr,
  input  logic             write,
  input  logic [7:0]       write_data,
  output logic [7:0]       from_memory,
  input  logic [8*N_IN-1:0]  port_in,
  output logic [8*N_OUT-1:0] port_out,
  input  logic             boot_valid,
  input  logic [7:0]       boot_addr,
  input  logic [7:0]       boot_data,
  input  logic             boot_done,
  output logic             boot_ready,
  output logic             cpu_hold,
  output logic             rom_wr_err
);

  localparam resp_state_t RESET_STATE = BOOT_EN ? BOOT : RUN;
  localparam logic [7:0]  ROM_LIMIT   = 8'(ROM_DEPTH);
  localparam logic [7:0]  RAM_LIMIT   = 8'(RAM_DEPTH);
  localparam logic [4:0]  OUT_LIMIT   = 5'(N_OUT);
  localparam logic [4:0]  IN_LIMIT    = 5'(N_IN);

  resp_state_t state, state_nxt;
  logic [7:0]  mar;
  logic [7:0]  rom [ROM_DEPTH];
  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  out_q [N_OUT];
  logic [7:0]  in_sync [N_IN];

  logic        in_run, in_boot;
  logic        wr_en;
  logic [7:0]  wr_addr, wr_dat;
  region_t     wr_region, rd_region;
  logic        rom_we, ram_we, out_we, rom_err_set, wr_fwd;
  logic [7:0]  rd_data;

  function automatic logic rom_pop(input logic [7:0] a);
    return ({1'b0, a[6:0]} < ROM_LIMIT);
  endfunction

  function automatic logic ram_pop(input logic [7:0] a);
    return ({1'b0, a[6:0]} < RAM_LIMIT);
  endfunction

  function automatic logic out_pop(input logic [7:0] a);
    return ({1'b0, a[3:0]} < OUT_LIMIT);
  endfunction

  function automatic logic in_pop(input logic [7:0] a);
    return ({1'b0, a[3:0]} < IN_LIMIT);
  endfunction

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    port_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (port_in[8*k +: 8]),
      .q     (in_sync[k])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign port_out[8*k +: 8] = out_q[k];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RESET_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    boot_ready = 1'b0;
    cpu_hold   = 1'b0;
    case (state)
      BOOT: begin
        boot_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (boot_done) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      default: state_nxt = RESET_STATE;
    endcase
  end

  // One write port shared by the boot loader and the CPU; in RUN the write address is MAR.
  always_comb begin
    in_run      = (state == RUN);
    in_boot     = (state == BOOT);
    wr_en       = in_boot ? boot_valid : write;
    wr_addr     = in_boot ? boot_addr  : mar;
    wr_dat      = in_boot ? boot_data  : write_data;
    wr_region   = region_of(wr_addr);
    rd_region   = region_of(mar);
    rom_we      = in_boot && wr_en && (wr_region == REG_ROM) && rom_pop(wr_addr);
    ram_we      = wr_en && (wr_region == REG_RAM) && ram_pop(wr_addr);
    out_we      = in_run && write && (rd_region == REG_OUT) && out_pop(mar);
    rom_err_set = in_run && write && (rd_region == REG_ROM) && rom_pop(mar);
    wr_fwd      = (in_run && ram_we) || out_we;
  end

  always_comb begin
    rd_data = '0;
    case (rd_region)
      REG_ROM: if (rom_pop(mar)) rd_data = rom[mar[6:0]];
      REG_RAM: if (ram_pop(mar)) rd_data = ram[mar[6:0]];
      REG_OUT: if (out_pop(mar)) rd_data = out_q[mar[3:0]];
      REG_IN:  if (in_pop(mar))  rd_data = in_sync[mar[3:0]];
      default: rd_data = '0;
    endcase
  end

  // Storage arrays keep their contents through reset so a reboot can reuse the program.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (rom_we) rom[wr_addr[6:0]] <= wr_dat;
      if (ram_we) ram[wr_addr[6:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mar         <= '0;
      from_memory <= '0;
      rom_wr_err  <= 1'b0;
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
    end else begin
      if (in_run && mar_load) mar <= mar_addr;
      if (rom_err_set) rom_wr_err <= 1'b1;
      if (out_we) out_q[mar[3:0]] <= write_data;
      if (!in_run)     from_memory <= '0;
      else if (wr_fwd) from_memory <= write_data;
      else             from_memory <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: boot load, read timing, write-first, ROM protect, ports, reset.
module tb_memory_responder;
  import mem_map_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         mar_load;
  logic [7:0]   mar_addr;
  logic         write;
  logic [7:0]   write_data;
  logic [7:0]   from_memory;
  logic [127:0] port_in;
  logic [127:0] port_out;
  logic         boot_valid;
  logic [7:0]   boot_addr;
  logic [7:0]   boot_data;
  logic         boot_done;
  logic         boot_ready;
  logic         cpu_hold;
  logic         rom_wr_err;

  int checks = 0;
  int errors = 0;

  memory_responder dut (
    .clk         (clk),
    .reset       (reset),
    .mar_load    (mar_load),
    .mar_addr    (mar_addr),
    .write       (write),
    .write_data  (write_data),
    .from_memory (from_memory),
    .port_in     (port_in),
    .port_out    (port_out),
    .boot_valid  (boot_valid),
    .boot_addr   (boot_addr),
    .boot_data   (boot_data),
    .boot_done   (boot_done),
    .boot_ready  (boot_ready),
    .cpu_hold    (cpu_hold),
    .rom_wr_err  (rom_wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic boot_wr(input logic [7:0] a, input logic [7:0] d);
    boot_valid = 1'b1;
    boot_addr  = a;
    boot_data  = d;
    tick();
    boot_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    mar_load = 1'b1;
    mar_addr = a;
    tick();
    mar_load = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; mar_load = 1'b0; mar_addr = '0; write = 1'b0; write_data = '0;
    port_in = '0; boot_valid = 1'b0; boot_addr = '0; boot_data = '0; boot_done = 1'b0;
    tick();
    tick();
    check("rst_from_memory", from_memory, 8'h00);
    check("rst_port_out",    port_out,    '0);
    check("rst_rom_wr_err",  rom_wr_err,  1'b0);
    check("rst_boot_ready",  boot_ready,  1'b1);
    check("rst_cpu_hold",    cpu_hold,    1'b1);

    // Boot load; CPU strobes in the first step must be ignored.
    reset = 1'b1;
    mar_load = 1'b1; mar_addr = 8'h02; write = 1'b1; write_data = 8'hEE;
    boot_wr(8'h00, 8'h80);
    mar_load = 1'b0; write = 1'b0;
    check("boot_from_memory_held", from_memory, 8'h00);
    boot_wr(8'h01, 8'h03);
    boot_wr(8'h10, 8'h5C);
    boot_wr(8'h91, 8'h44);
    boot_wr(8'hDF, 8'hA5);
    boot_wr(8'hE5, 8'h99);
    check("boot_port_ignored", port_out, '0);
    boot_done = 1'b1;
    boot_wr(8'h02, 8'h2A);
    boot_done = 1'b0;
    check("run_cpu_hold",   cpu_hold,   1'b0);
    check("run_boot_ready", boot_ready, 1'b0);

    // Read timing: data valid after the second edge.
    mar_load = 1'b1; mar_addr = 8'h01;
    tick();
    mar_load = 1'b0;
    check("read_edge1_old_mar", from_memory, 8'h80);
    tick();
    check("read_rom01", from_memory, 8'h03);
    cpu_read(8'h02);
    check("read_rom02_done_cycle", from_memory, 8'h2A);
    cpu_read(8'h00);
    check("read_rom00", from_memory, 8'h80);

    // RAM write-first and re-read.
    mar_load = 1'b1; mar_addr = 8'h90;
    tick();
    mar_load = 1'b0; write = 1'b1; write_data = 8'h5A;
    tick();
    write = 1'b0;
    check("ram_write_first", from_memory, 8'h5A);
    cpu_read(8'h00);
    cpu_read(8'h90);
    check("ram_reread", from_memory, 8'h5A);

    // mar_load with write: the write lands at the old MAR.
    mar_load = 1'b1; mar_addr = 8'h91; write = 1'b1; write_data = 8'h33;
    tick();
    mar_load = 1'b0; write = 1'b0;
    check("mar_wr_same_fwd", from_memory, 8'h33);
    tick();
    check("mar_wr_new_addr", from_memory, 8'h44);
    cpu_read(8'h90);
    check("mar_wr_old_addr", from_memory, 8'h33);
    cpu_read(8'hDF);
    check("ram_top_boundary", from_memory, 8'hA5);

    // ROM write protection.
    cpu_read(8'h10);
    write = 1'b1; write_data = 8'hFF;
    tick();
    write = 1'b0;
    check("rom_err_set", rom_wr_err, 1'b1);
    tick();
    check("rom_unchanged", from_memory, 8'h5C);

    // Output ports.
    mar_load = 1'b1; mar_addr = 8'hE3;
    tick();
    mar_load = 1'b0; write = 1'b1; write_data = 8'hC4;
    tick();
    write = 1'b0;
    check("out_port3", port_out, {96'h0, 8'hC4, 24'h0});
    tick();
    check("out_read_back", from_memory, 8'hC4);
    mar_load = 1'b1; mar_addr = 8'hEF;
    tick();
    mar_load = 1'b0; write = 1'b1; write_data = 8'h3C;
    tick();
    write = 1'b0;
    check("out_port15", port_out[127:120], 8'h3C);

    // Input port synchroniser latency.
    cpu_read(8'hF2);
    check("in_initial", from_memory, 8'h00);
    port_in[23:16] = 8'h7E;
    tick();
    check("in_edge1", from_memory, 8'h00);
    tick();
    check("in_edge2", from_memory, 8'h00);
    tick();
    check("in_edge3", from_memory, 8'h7E);
    write = 1'b1; write_data = 8'h11;
    tick();
    write = 1'b0;
    check("in_write_ignored", from_memory, 8'h7E);
    check("rom_err_sticky", rom_wr_err, 1'b1);

    // Reset in RUN, then reboot without reloading.
    mar_load = 1'b1; mar_addr = 8'h55;
    tick();
    mar_load = 1'b0; reset = 1'b0;
    tick();
    check("rst2_from_memory", from_memory, 8'h00);
    check("rst2_port_out",    port_out,    '0);
    check("rst2_cpu_hold",    cpu_hold,    1'b1);
    check("rst2_boot_ready",  boot_ready,  1'b1);
    check("rst2_rom_wr_err",  rom_wr_err,  1'b0);
    reset = 1'b1; boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    check("rst2_run", cpu_hold, 1'b0);
    cpu_read(8'h01);
    check("rom_persists", from_memory, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
